// File: rtl/avalon_copy.sv
// avalon_copy: Avalon MM master that copies a block of words from a source
// region to a destination region, one word at a time (read, then write).
// The copy is strictly ascending, so an overlapping destination (dst = src+1)
// replicates the first source word across the block.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   cmd_start                start pulse, accepted only in idle
//   cmd_src/cmd_dst/cmd_len  source/destination word address, word count
//   cmd_busy, cmd_done       busy during the transfer, one-cycle completion pulse
//   read, write, address,    Avalon MM master side; all outputs are registered
//   byteenable, writedata
//   readdata, waitrequest    Avalon MM slave response
module avalon_copy #(
  parameter int unsigned ADW = 32,
  parameter int unsigned ABW = ADW / 8,
  parameter int unsigned AAW = 8,
  parameter int unsigned ALW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_start,
  input  logic [AAW-1:0] cmd_src,
  input  logic [AAW-1:0] cmd_dst,
  input  logic [ALW-1:0] cmd_len,
  output logic           cmd_busy,
  output logic           cmd_done,
  output logic           read,
  output logic           write,
  output logic [AAW-1:0] address,
  output logic [ABW-1:0] byteenable,
  output logic [ADW-1:0] writedata,
  input  logic [ADW-1:0] readdata,
  input  logic           waitrequest
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e         state_q, state_d;
  logic [AAW-1:0] src_q, src_d;
  logic [AAW-1:0] dst_q, dst_d;
  logic [ALW-1:0] rem_q, rem_d;
  logic [ADW-1:0] word_q, word_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           read_q, read_d;
  logic           write_q, write_d;
  logic [AAW-1:0] addr_q, addr_d;
  logic [ABW-1:0] be_q, be_d;
  logic [ADW-1:0] wdata_q, wdata_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      word_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  // Output registers are computed alongside the next state so that every
  // strobe/address change lands exactly with the state it belongs to.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    word_d  = word_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    read_d  = read_q;
    write_d = write_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_start) begin
          src_d = cmd_src;
          dst_d = cmd_dst;
          rem_d = cmd_len;
          if (cmd_len != '0) begin
            state_d = StRd;
            busy_d  = 1'b1;
            read_d  = 1'b1;
            addr_d  = cmd_src;
            be_d    = '1;
          end else begin
            // Empty block: complete without touching the bus.
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StRd: begin
        if (!waitrequest) begin
          state_d = StWr;
          word_d  = readdata;
          read_d  = 1'b0;
          write_d = 1'b1;
          addr_d  = dst_q;
          wdata_d = readdata;
        end
      end
      StWr: begin
        if (!waitrequest) begin
          src_d   = src_q + AAW'(1);
          dst_d   = dst_q + AAW'(1);
          rem_d   = rem_q - ALW'(1);
          write_d = 1'b0;
          if (rem_q == ALW'(1)) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = StRd;
            read_d  = 1'b1;
            addr_d  = src_q + AAW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign cmd_busy   = busy_q;
  assign cmd_done   = done_q;
  assign read       = read_q;
  assign write      = write_q;
  assign address    = addr_q;
  assign byteenable = be_q;
  assign writedata  = wdata_q;

endmodule

// File: tb/tb_avalon_copy.sv
// tb_avalon_copy: directed bench for avalon_copy against a behavioural
// word RAM slave (one-wait read, zero-wait write, or random stalls).
module tb_avalon_copy;

  localparam int unsigned ADW = 32;
  localparam int unsigned ABW = 4;
  localparam int unsigned AAW = 8;
  localparam int unsigned ALW = 8;

  logic           clk;
  logic           rst_n;
  logic           cmd_start;
  logic [AAW-1:0] cmd_src, cmd_dst;
  logic [ALW-1:0] cmd_len;
  logic           cmd_busy, cmd_done;
  logic           read, write;
  logic [AAW-1:0] address;
  logic [ABW-1:0] byteenable;
  logic [ADW-1:0] writedata, readdata;
  logic           waitrequest;

  avalon_copy #(.ADW(ADW), .ABW(ABW), .AAW(AAW), .ALW(ALW)) dut (
    .clk         (clk),
    .rst         (rst_n),
    .cmd_start   (cmd_start),
    .cmd_src     (cmd_src),
    .cmd_dst     (cmd_dst),
    .cmd_len     (cmd_len),
    .cmd_busy    (cmd_busy),
    .cmd_done    (cmd_done),
    .read        (read),
    .write       (write),
    .address     (address),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .readdata    (readdata),
    .waitrequest (waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model
  logic [ADW-1:0] mem [0:255];
  logic [AAW-1:0] rd_log [0:1023];
  logic           stall_on, rnd_in, rnd_wait;
  logic [ADW-1:0] rnd_data;
  logic           poke_en;
  logic [AAW-1:0] poke_addr;
  logic [ADW-1:0] poke_data;
  logic [2:0]     rd_cnt, wr_cnt;
  int             n_rd, n_wr, stable_bad, both_bad;
  logic           prev_stall;
  logic [47:0]    prev_snap, snap;

  assign readdata    = rnd_in ? rnd_data : mem[address];
  assign waitrequest = rnd_in ? rnd_wait :
                       read   ? (rd_cnt != 3'd0) :
                       write  ? (wr_cnt != 3'd0) : 1'b0;
  assign snap = {read, write, address, byteenable, (write ? writedata : 32'h0)};

  initial begin
    n_rd = 0; n_wr = 0; stable_bad = 0; both_bad = 0;
    prev_stall = 1'b0; prev_snap = '0; rd_cnt = 3'd1; wr_cnt = 3'd0;
  end

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    if (read && !waitrequest) begin
      rd_log[n_rd % 1024] <= address;
      n_rd <= n_rd + 1;
    end
    if (write && !waitrequest) begin
      mem[address] <= writedata;
      n_wr <= n_wr + 1;
    end
    if (!(read || write) || !waitrequest) begin
      rd_cnt <= stall_on ? 3'($urandom_range(5, 0)) : 3'd1;
      wr_cnt <= stall_on ? 3'($urandom_range(5, 0)) : 3'd0;
    end else if (read) begin
      rd_cnt <= rd_cnt - 3'd1;
    end else begin
      wr_cnt <= wr_cnt - 3'd1;
    end
  end

  // Bus-protocol monitor: stalled cycles must repeat the previous bus state.
  always @(posedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (snap != prev_snap)) stable_bad <= stable_bad + 1;
      if (read && write) both_bad <= both_bad + 1;
      prev_stall <= (read || write) && waitrequest;
      prev_snap  <= snap;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic poke(input logic [AAW-1:0] a, input logic [ADW-1:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Issue a start at the next negedge; returns in cycle 1 (after the sampling edge).
  task automatic start(input logic [AAW-1:0] s, input logic [AAW-1:0] d,
                       input logic [ALW-1:0] n);
    @(negedge clk);
    cmd_src = s; cmd_dst = d; cmd_len = n; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (cmd_done) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  int rd0, wr0, sb0, bb0;

  initial begin
    rst_n = 1'b0; cmd_start = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
    stall_on = 1'b0; rnd_in = 1'b1; rnd_wait = 1'b0; rnd_data = '0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;

    // Reset held with random inputs: every output stays zero.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmd_start = 1'($urandom); cmd_src = 8'($urandom); cmd_dst = 8'($urandom);
      cmd_len = 8'($urandom); rnd_wait = 1'($urandom); rnd_data = $urandom;
      #1;
      check("reset_outputs",
            64'({read, write, cmd_busy, cmd_done, address, byteenable, writedata}), 64'd0);
    end
    @(negedge clk);
    cmd_start = 1'b0; rnd_in = 1'b0; rnd_wait = 1'b0;
    rst_n = 1'b1;

    // Basic 4-word copy with cycle-exact timing.
    poke(8'd0, 32'h11); poke(8'd1, 32'h22); poke(8'd2, 32'h33); poke(8'd3, 32'h44);
    rd0 = n_rd; wr0 = n_wr; sb0 = stable_bad; bb0 = both_bad;
    start(8'd0, 8'd16, 8'd4);
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) @(negedge clk);
      check($sformatf("copy_busy_c%0d", k), 64'(cmd_busy), 64'(k <= 12));
      check($sformatf("copy_done_c%0d", k), 64'(cmd_done), 64'(k == 13));
      check($sformatf("copy_read_c%0d", k), 64'(read), 64'((k % 3 != 0) && k <= 12));
      check($sformatf("copy_write_c%0d", k), 64'(write), 64'((k % 3 == 0) && k <= 12));
    end
    check("copy_mem16", 64'(mem[16]), 64'h11);
    check("copy_mem17", 64'(mem[17]), 64'h22);
    check("copy_mem18", 64'(mem[18]), 64'h33);
    check("copy_mem19", 64'(mem[19]), 64'h44);
    check("copy_nrd", 64'(n_rd - rd0), 64'd4);
    check("copy_nwr", 64'(n_wr - wr0), 64'd4);

    // Zero-length block: done next cycle, no bus activity.
    rd0 = n_rd; wr0 = n_wr;
    start(8'd5, 8'd6, 8'd0);
    check("len0_done", 64'({cmd_done, cmd_busy}), 64'b10);
    @(negedge clk);
    check("len0_done_off", 64'({cmd_done, cmd_busy, read, write}), 64'd0);
    repeat (3) @(negedge clk);
    check("len0_nrd", 64'(n_rd - rd0), 64'd0);
    check("len0_nwr", 64'(n_wr - wr0), 64'd0);

    // Address wrap, with start asserted while busy (must be ignored).
    poke(8'hFE, 32'hCAFE0001); poke(8'hFF, 32'hCAFE0002); poke(8'h00, 32'hCAFE0003);
    rd0 = n_rd; wr0 = n_wr;
    start(8'hFE, 8'h10, 8'd3);
    @(negedge clk);
    cmd_src = 8'h40; cmd_dst = 8'h50; cmd_len = 8'd5; cmd_start = 1'b1;
    repeat (4) @(negedge clk);
    cmd_start = 1'b0;
    wait_done("wrap_done", 50);
    repeat (6) @(negedge clk);
    check("wrap_nrd", 64'(n_rd - rd0), 64'd3);
    check("wrap_nwr", 64'(n_wr - wr0), 64'd3);
    check("wrap_rd0", 64'(rd_log[rd0 % 1024]), 64'hFE);
    check("wrap_rd1", 64'(rd_log[(rd0 + 1) % 1024]), 64'hFF);
    check("wrap_rd2", 64'(rd_log[(rd0 + 2) % 1024]), 64'h00);
    check("wrap_mem10", 64'(mem[8'h10]), 64'hCAFE0001);
    check("wrap_mem12", 64'(mem[8'h12]), 64'hCAFE0003);

    // Random stalls: same result, bus held stable while stalled.
    stall_on = 1'b1;
    for (int i = 0; i < 8; i++) poke(8'(32 + i), 32'hA0000000 + 32'(i) * 32'h1357);
    start(8'd32, 8'd64, 8'd8);
    wait_done("stall_done", 800);
    for (int i = 0; i < 8; i++)
      check($sformatf("stall_mem%0d", 64 + i), 64'(mem[64 + i]),
            64'(32'hA0000000 + 32'(i) * 32'h1357));
    stall_on = 1'b0;

    // Overlapping dst = src + 1 replicates the first word.
    poke(8'd0, 32'hA5); poke(8'd1, 32'h5A); poke(8'd2, 32'h5B); poke(8'd3, 32'h5C);
    start(8'd0, 8'd1, 8'd3);
    wait_done("ovl_done", 50);
    check("ovl_mem1", 64'(mem[1]), 64'hA5);
    check("ovl_mem2", 64'(mem[2]), 64'hA5);
    check("ovl_mem3", 64'(mem[3]), 64'hA5);

    // Asynchronous reset in the middle of a read.
    wr0 = n_wr;
    start(8'd0, 8'h80, 8'd2);
    check("midrd_read", 64'(read), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrd_async", 64'({read, write, cmd_busy, address}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrd_nwr", 64'(n_wr - wr0), 64'd0);
    check("midrd_idle", 64'({read, write, cmd_busy, cmd_done}), 64'd0);

    check("stable_while_stalled", 64'(stable_bad - sb0), 64'd0);
    check("read_write_exclusive", 64'(both_bad - bb0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
